// File: rtl/instr_fetch_pkg.sv
// cpu_pkg: shared constants and next-PC select encoding for the fetch stage
// Holds the reset/interrupt/exception vectors, the bubble instruction and the
// select enum produced by if_pc_sel.
package cpu_pkg;
  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8040_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8040_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [2:0] {SEL_SEQ, SEL_HOLD, SEL_JUMP, SEL_BR, SEL_JR, SEL_IRQ, SEL_EXC} pc_sel_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: combinational instruction-memory read port
// imem_addr : fetch address driven by the fetch stage (master)
// imem_data : instruction word returned by memory (slave) in the same cycle
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  modport master(output imem_addr, input imem_data);
  modport slave(input imem_addr, output imem_data);
endinterface

// File: rtl/if_pc_sel.sv
// if_pc_sel: combinational next-PC select and value for the fetch stage
// Inputs : current pc plus all redirect/hold/trap requests
// Outputs: sel (chosen source), next_pc, pc4 (pc+4), redir_pc (active redirect
//          target or pc, used as the interrupt return address)
// Optional: IF_IRQ_EN enables the timer-interrupt path; otherwise irq is ignored.
module if_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output pc_sel_e     sel,
  output logic [31:0] next_pc,
  output logic [31:0] pc4,
  output logic [31:0] redir_pc
);
  logic        irq_take;
  logic [31:0] jmp_pc;
`ifdef IF_IRQ_EN
  // Interrupts are masked in kernel mode (pc[31]) and lose to an exception.
  assign irq_take = irq && !pc[31] && !exc;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
`endif
  // Plain 32-bit modulo add: 32'hFFFFFFFC wraps to zero.
  assign pc4      = pc + 32'd4;
  assign jmp_pc   = {pc[31:28], jump_index, 2'b00};
  assign redir_pc = jr ? jr_target : branch_taken ? branch_target : jump ? jmp_pc : pc;
  assign sel      = exc ? SEL_EXC : irq_take ? SEL_IRQ : jr ? SEL_JR : branch_taken ? SEL_BR :
                    jump ? SEL_JUMP : stall ? SEL_HOLD : SEL_SEQ;
  always_comb
    case (sel)
      SEL_EXC:  next_pc = EXC_VEC;
      SEL_IRQ:  next_pc = IRQ_VEC;
      SEL_JR:   next_pc = jr_target;
      SEL_BR:   next_pc = branch_target;
      SEL_JUMP: next_pc = jmp_pc;
      SEL_HOLD: next_pc = pc;
      default:  next_pc = pc4;
    endcase
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage holding the PC, the IF/ID register and the EPC
// clk/reset : clock and synchronous active-high reset
// stall/flush, branch_*, jump*, jr*, irq, exc : control from later stages
// bus (master) : imem_addr = PC, imem_data read back in the same cycle
// ifid_instr/ifid_pc4/ifid_valid : IF/ID pipeline register; epc : trap return address
// Optional: IF_IRQ_EN enables the timer-interrupt path (see if_pc_sel).
module instr_fetch
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jr,
  input  logic [31:0]          jr_target,
  input  logic                 irq,
  input  logic                 exc,
  instr_fetch_if.master        bus,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc4,
  output logic                 ifid_valid,
  output logic [31:0]          epc
);
  logic [31:0] pc_q, next_pc, pc4, redir_pc;
  logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d, epc_q, epc_d;
  logic        ifid_valid_q, ifid_valid_d, bubble, hold;
  pc_sel_e     sel;
  if_pc_sel u_sel (
    .pc(pc_q), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .irq(irq), .exc(exc), .sel(sel), .next_pc(next_pc), .pc4(pc4), .redir_pc(redir_pc)
  );
  // Every redirect or trap costs exactly one bubble; flush squashes IF/ID too.
  assign bubble = flush || !(sel inside {SEL_SEQ, SEL_HOLD});
  assign hold   = sel == SEL_HOLD;
  always_comb begin
    ifid_instr_d = bubble ? NOP_INSTR : hold ? ifid_instr_q : bus.imem_data;
    ifid_pc4_d   = hold ? ifid_pc4_q : pc4;
    ifid_valid_d = !bubble && (hold ? ifid_valid_q : 1'b1);
    epc_d        = sel == SEL_EXC ? ifid_pc4_q : sel == SEL_IRQ ? redir_pc : epc_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc_q         <= RESET_VEC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      epc_q        <= '0;
    end else begin
      pc_q         <= next_pc;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      epc_q        <= epc_d;
    end
  assign bus.imem_addr = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc4      = ifid_pc4_q;
  assign ifid_valid    = ifid_valid_q;
  assign epc           = epc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch (default build or IF_IRQ_EN)
module tb_instr_fetch;
  typedef struct {
    logic stall, flush, br; logic [31:0] brt;
    logic j; logic [25:0] ji;
    logic jr; logic [31:0] jrt;
    logic irq, exc;
  } stim_t;
  typedef struct {
    string name; logic [31:0] pc, instr, pc4; logic valid; logic [31:0] epc;
  } exp_t;
  logic clk = 0, reset = 1, stall = 0, flush = 0, branch_taken = 0, jump = 0, jr = 0, irq = 0, exc = 0;
  logic [31:0] branch_target = 0, jr_target = 0;
  logic [25:0] jump_index = 0;
  logic [31:0] ifid_instr, ifid_pc4, epc, m_epc;
  logic ifid_valid;
  int errors = 0, checks = 0;
  exp_t sb[$];
  instr_fetch_if bus();
  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_target(jr_target), .irq(irq), .exc(exc), .bus(bus), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .epc(epc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a == 32'h0040_0000 ? 32'h0810_003d : a ^ 32'h5A5A_5A5A;
  endfunction
  assign bus.imem_data = instr_of(bus.imem_addr);
  function automatic stim_t mk(logic s, logic f, logic b, logic [31:0] bt, logic jj,
                               logic [25:0] ji, logic r, logic [31:0] rt, logic i, logic e);
    return '{stall:s, flush:f, br:b, brt:bt, j:jj, ji:ji, jr:r, jrt:rt, irq:i, exc:e};
  endfunction
  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic stim_t to_jr(logic [31:0] t);
    return mk(0, 0, 0, 0, 0, 0, 1, t, 0, 0);
  endfunction
  task automatic drive(stim_t s);
    stall = s.stall; flush = s.flush; branch_taken = s.br; branch_target = s.brt;
    jump = s.j; jump_index = s.ji; jr = s.jr; jr_target = s.jrt; irq = s.irq; exc = s.exc;
  endtask
  task automatic push(string n, logic [31:0] pc, logic [31:0] ins, logic [31:0] p4, logic v);
    sb.push_back('{name:n, pc:pc, instr:ins, pc4:p4, valid:v, epc:m_epc});
  endtask
  task automatic push_bubble(string n, logic [31:0] pc);
    push(n, pc, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset(stim_t s);
    drive(s); reset = 1; m_epc = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_addr !== 32'h0040_0000 || ifid_instr !== 0 || ifid_pc4 !== 0 || ifid_valid !== 0 || epc !== 0) begin
      errors++;
      $display("FAIL reset: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=00400000 instr=0 pc4=0 v=0 epc=0",
               bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc);
    end
    reset = 0;
  endtask

  task automatic test_seq();
    stim_t st[$];
    exp_t e;
    st.push_back(idle()); push("seq0", 32'h0040_0004, 32'h0810_003d, 32'h0040_0004, 1);
    st.push_back(idle()); push("seq1", 32'h0040_0008, instr_of(32'h0040_0004), 32'h0040_0008, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[$];
    exp_t e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); push("stall0", 32'h0040_0008, instr_of(32'h0040_0004), 32'h0040_0008, 1);
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); push("stall1", 32'h0040_0008, instr_of(32'h0040_0004), 32'h0040_0008, 1);
    st.push_back(idle()); push("unstall", 32'h0040_000C, instr_of(32'h0040_0008), 32'h0040_000C, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t st[$];
    exp_t e;
    st.push_back(mk(0, 0, 0, 0, 1, 26'h010_0022, 0, 0, 0, 0)); push_bubble("jump", 32'h0040_0088);
    st.push_back(mk(1, 0, 1, 32'h0040_00dc, 0, 0, 0, 0, 0, 0)); push_bubble("branch_over_stall", 32'h0040_00dc);
    st.push_back(idle()); push("after_branch", 32'h0040_00e0, instr_of(32'h0040_00dc), 32'h0040_00e0, 1);
    st.push_back(mk(0, 0, 1, 32'h0040_0300, 1, 26'h010_0100, 1, 32'h0040_0200, 0, 0)); push_bubble("jr_wins", 32'h0040_0200);
    st.push_back(mk(0, 0, 1, 32'h0040_0500, 1, 26'h010_0100, 0, 0, 0, 0)); push_bubble("br_over_jump", 32'h0040_0500);
    st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); push_bubble("flush", 32'h0040_0504);
    st.push_back(idle()); push("after_flush", 32'h0040_0508, instr_of(32'h0040_0504), 32'h0040_0508, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_kernel_jump();
    stim_t st[$];
    exp_t e;
    st.push_back(to_jr(32'h8040_0160)); push_bubble("jr_kernel", 32'h8040_0160);
    st.push_back(mk(0, 0, 0, 0, 1, 26'h010_0070, 0, 0, 0, 0)); push_bubble("jump_keeps_kbit", 32'h8040_01C0);
    st.push_back(idle()); push("kernel_seq", 32'h8040_01C4, instr_of(32'h8040_01C0), 32'h8040_01C4, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_exc();
    stim_t st[$];
    exp_t e;
    st.push_back(to_jr(32'h0040_0054)); push_bubble("to_user", 32'h0040_0054);
    st.push_back(idle()); push("fill_ifid", 32'h0040_0058, instr_of(32'h0040_0054), 32'h0040_0058, 1);
    m_epc = 32'h0040_0058;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0040_0300, 1, 1)); push_bubble("exc_wins", 32'h8040_0008);
    st.push_back(idle()); push("exc_handler", 32'h8040_000C, instr_of(32'h8040_0008), 32'h8040_000C, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_irq();
    stim_t st[$];
    exp_t e;
    st.push_back(to_jr(32'h0040_0154)); push_bubble("irq_setup", 32'h0040_0154);
`ifdef IF_IRQ_EN
    m_epc = 32'h0040_0154;
    st.push_back(mk(0, 0, 0, 0, 1, 26'h010_0055, 0, 0, 1, 0)); push_bubble("irq_with_jump", 32'h8040_0004);
    st.push_back(to_jr(32'h8040_0160)); push_bubble("to_kernel", 32'h8040_0160);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); push("irq_masked", 32'h8040_0164, instr_of(32'h8040_0160), 32'h8040_0164, 1);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8040_01b4, 1, 0)); push_bubble("masked_jr", 32'h8040_01b4);
    st.push_back(to_jr(32'h0040_0154)); push_bubble("irq_return", 32'h0040_0154);
    st.push_back(idle()); push("user_seq", 32'h0040_0158, instr_of(32'h0040_0154), 32'h0040_0158, 1);
    foreach (st[i]) begin
      if (i == 7) m_epc = 32'h0040_0158;
    end
    m_epc = 32'h0040_0158;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); push_bubble("irq_over_stall", 32'h8040_0004);
`else
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); push("irq_ignored", 32'h0040_0158, instr_of(32'h0040_0154), 32'h0040_0158, 1);
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); push("irq_ignored_stall", 32'h0040_0158, instr_of(32'h0040_0154), 32'h0040_0158, 1);
`endif
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    exp_t e;
    st.push_back(to_jr(32'hFFFF_FFFC)); push_bubble("to_top", 32'hFFFF_FFFC);
    st.push_back(idle()); push("wrap", 32'h0000_0000, instr_of(32'hFFFF_FFFC), 32'h0000_0000, 1);
    foreach (st[i]) begin
      drive(st[i]); @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (bus.imem_addr !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid || (e.valid && ifid_pc4 !== e.pc4) || epc !== e.epc) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b epc=%h want pc=%h instr=%h pc4=%h v=%b epc=%h",
                 e.name, bus.imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc, e.pc, e.instr, e.pc4, e.valid, e.epc);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_epc = 0;
    test_reset(mk(1, 1, 1, 32'h1234_5678, 1, 26'h3FF_FFFF, 1, 32'h8765_4320, 1, 1));
    test_seq();
    test_stall();
    test_redirect();
    test_kernel_jump();
    test_exc();
    test_irq();
    test_wrap();
    test_reset(mk(1, 0, 0, 0, 0, 0, 1, 32'h0040_0800, 1, 1));
    test_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
